mux_arb_nxw: RTL and testbench
==============================

MUX_ARB_NXW -- requirements
Module: mux_arb_nxw

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width per channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 8, number of input channels (2..16).
REQ-003 The block SHALL have localparam SEL_W = clog2(CHANNELS), channel index width.
REQ-004 clk  input  1  sole clock, rising edge; one clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  CHANNELS*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel request.
REQ-008 in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
REQ-009 mode  input  1  0 = explicit select, 1 = round-robin.
REQ-010 sel  input  SEL_W  channel index used in explicit mode.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output register holds a word.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both high at a rising clk edge.
REQ-016 in_ready SHALL be asserted only for the granted channel, and only when the output register is free: out_valid=0, or out_valid=1 and out_ready=1 in the same cycle.
REQ-017 Grant SHALL be combinational from in_valid, mode, sel and the RR pointer; it SHALL not depend on out_ready except through REQ-016.
REQ-018 In explicit mode, the granted channel SHALL be sel if in_valid[sel]=1; otherwise no channel is granted.
REQ-019 In explicit mode with sel >= CHANNELS, no channel SHALL be granted.
REQ-020 In round-robin mode, the search SHALL start at channel ptr and wrap modulo CHANNELS; the first channel with valid set SHALL be granted.
REQ-021 After each round-robin transfer from channel g, ptr SHALL become (g+1) mod CHANNELS; wrap from CHANNELS-1 SHALL go to 0.
REQ-022 Explicit-mode transfers SHALL NOT modify ptr.
REQ-023 Latency SHALL be one cycle: data accepted at edge k SHALL appear on out_data/out_chan with out_valid=1 after edge k.
REQ-024 If out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-025 Simultaneous drain and fill SHALL load the new word with out_valid staying 1, giving full throughput of one word per cycle.
REQ-026 Drain without fill SHALL clear out_valid on the next edge.
REQ-027 A mode or sel change SHALL affect only the next grant; a word already held SHALL be unaffected.
REQ-028 The output register SHALL hold at most one word; no other buffering is allowed.

Reset
REQ-029 While rst_n=0: out_valid=0, out_data=0, out_chan=0, ptr=0, and in_ready=0.
REQ-030 Assertion of rst_n mid-transfer SHALL discard the held word immediately and asynchronously.
REQ-031 Deassertion of rst_n SHALL be taken synchronously; the first transfer is allowed on the first edge after release.

Structure
REQ-032 Shared package mux_pkg SHALL hold the mode constants MODE_SEL=0 and MODE_RR=1 and the clog2 helper function.
REQ-033 The round-robin search SHALL be a combinational sub-module rr_pick, parameterised by CHANNELS, with inputs req and ptr and outputs gnt_idx and gnt_any.
REQ-034 The top level SHALL contain the grant mux, the output register and the ptr register only.

Verification
REQ-035 Explicit mode: mode=0, sel=3, in_valid=8'hFF, ch3 data=32'hA5A5_0003 -> in_ready=8'h08 and, after the edge, out_data=32'hA5A5_0003, out_chan=3.
REQ-036 RR fairness: mode=1, in_valid=8'h81, out_ready=1 for 4 cycles -> grant sequence 0,7,0,7 and ptr ends at 0 (wrap).
REQ-037 Backpressure: out_valid=1, out_ready=0 for 5 cycles with all channels valid -> in_ready=0 throughout and out_data stable.
REQ-038 Full throughput: mode=1, in_valid=8'hFF, out_ready=1 for 8 cycles -> 8 words on out_chan 0..7 with out_valid continuously 1.
REQ-039 Edge cases: sel=7 with CHANNELS=6 -> in_ready=0 and no output; rst_n pulsed low while out_valid=1 -> out_valid=0 immediately and ptr=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel mux/arbiter.
// Mode encodings and a constant-foldable ceil(log2) for index widths.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nxw_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Purely combinational; the owning block keeps the pointer.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

  logic [SEL_W:0] cand;

  // Walk offsets high to low so the nearest requester is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (SEL_W+1)'(i);
      if (cand >= NCH) cand = cand - NCH;
      if (req[cand[SEL_W-1:0]]) begin
        gnt_idx = cand[SEL_W-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nxw.sv
// N-channel mux/arbiter with explicit or round-robin grant
// and a single registered output slot with valid/ready flow.
module mux_arb_nxw
  import mux_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int PAD_W = 1 << SEL_W;

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rrIdx;
  logic             rrAny;
  logic [SEL_W-1:0] gntIdx;
  logic             gntAny;
  logic [PAD_W-1:0] validPad;
  logic [WIDTH-1:0] chanData;
  logic             slotFree;
  logic             take;

  rr_pick #(.CHANNELS(CHANNELS)) uPick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rrIdx),
    .gnt_any (rrAny)
  );

  // Out-of-range selects land on zero padding and never grant.
  assign validPad = PAD_W'(in_valid);

  always_comb begin
    gntIdx = sel;
    gntAny = validPad[sel];
    if (mode == MODE_RR) begin
      gntIdx = rrIdx;
      gntAny = rrAny;
    end
  end

  always_comb begin
    chanData = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gntIdx == SEL_W'(i)) chanData = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign slotFree = !out_valid || out_ready;
  assign take     = rst_n && gntAny && slotFree;
  assign in_ready = take ? (CHANNELS'(1) << gntIdx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= chanData;
      out_chan  <= gntIdx;
      if (mode == MODE_RR) begin
        ptr <= (gntIdx == SEL_W'(CHANNELS - 1)) ? '0
             : gntIdx + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nxw.sv
// Directed bench for mux_arb_nxw with a queue scoreboard.
// A second 6-channel instance covers out-of-range selects.
module tb_mux_arb_nxw;

  typedef struct packed {
    logic [2:0]  chan;
    logic [31:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [31:0]  out_data;
  logic [2:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  logic [191:0] d6;
  logic [5:0]   v6;
  logic [5:0]   r6;
  logic [2:0]   sel6;
  logic [31:0]  od6;
  logic [2:0]   oc6;
  logic         ov6;

  int   checks = 0;
  int   failures = 0;
  int   mPtr = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mux_arb_nxw dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_arb_nxw #(.WIDTH(32), .CHANNELS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6),
    .in_valid(v6), .in_ready(r6),
    .mode(1'b0), .sel(sel6), .out_data(od6),
    .out_chan(oc6), .out_valid(ov6),
    .out_ready(1'b1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] chData(int i);
    return {8'hA5, 8'(8'hA5 + cyc), 8'h00, 8'(i)};
  endfunction

  task automatic fillData();
    for (int i = 0; i < 8; i++) in_data[i*32 +: 32] = chData(i);
  endtask

  function automatic int mGrant();
    int c;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 8; k++) begin
      c = (mPtr + k) % 8;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // Inputs are set just after a falling edge; one clock per call.
  task automatic tick();
    int   g;
    logic drain;
    logic [7:0] er;
    exp_t e;
    fillData();
    g = mGrant();
    er = 8'h00;
    if (g >= 0 && (q.size() == 0 || out_ready)) er = 8'(1 << g);
    #1;
    chk("in_ready", in_ready, er);
    drain = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (drain) void'(q.pop_front());
    if (er != 0) begin
      e.chan = 3'(g);
      e.data = chData(g);
      q.push_back(e);
      if (mode) mPtr = (g + 1) % 8;
    end
    cyc++;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_chan", out_chan, q[0].chan);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mode = 1'b0;
    sel = 3'd0;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    in_data = '0;
    d6 = '0;
    v6 = '0;
    sel6 = 3'd0;
    fillData();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_chan", out_chan, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ptr", dut.ptr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Explicit select of channel 3
    mode = 1'b0; sel = 3'd3; in_valid = 8'hFF;
    tick();
    chk("sel3_data", out_data, 32'hA5A5_0003);
    // Selected channel idle: no grant, slot drains
    in_valid = 8'hF7;
    tick();
    chk("sel_noptr", dut.ptr, 0);

    // Round-robin fairness with wrap
    mode = 1'b1; in_valid = 8'h81;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_chan", out_chan, (i % 2) ? 7 : 0);
    end
    chk("rr_ptr_wrap", dut.ptr, 0);

    // Backpressure, with mode/sel churn while the word is held
    in_valid = 8'hFF;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = i[0];
      sel = 3'(i + 2);
      tick();
    end
    chk("bp_ptr", dut.ptr, mPtr);

    // Asynchronous reset while holding a word
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ptr", dut.ptr, 0);
    chk("arst_in_ready", in_ready, 0);
    q.delete();
    mPtr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Full throughput round-robin over all channels
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tput_chan", out_chan, i);
    end
    in_valid = 8'h00;
    tick();

    // Six-channel instance: out-of-range select never grants
    v6 = 6'h3F;
    for (int i = 0; i < 6; i++) d6[i*32 +: 32] = 32'hC0DE_0000 + i;
    sel6 = 3'd7;
    #1;
    chk("c6_sel7_ready", r6, 0);
    @(posedge clk); #1;
    chk("c6_sel7_valid", ov6, 0);
    @(negedge clk);
    sel6 = 3'd5;
    #1;
    chk("c6_sel5_ready", r6, 6'h20);
    @(posedge clk); #1;
    chk("c6_sel5_valid", ov6, 1);
    chk("c6_sel5_chan", oc6, 5);
    chk("c6_sel5_data", od6, 32'hC0DE_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
